// File: rtl/com_pkg.sv
// Shared serial-port definitions: receiver state encoding, default oversample rate, frame bit counts.
// COM_RX_PARITY_EN selects whether frames carry an even parity bit.
`timescale 1ns/1ps
package com_pkg;

  localparam int OVS_DEFAULT = 16;
  localparam int START_BITS  = 1;
  localparam int DATA_BITS   = 8;
  localparam int STOP_BITS   = 1;
`ifdef COM_RX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif
  localparam int FRAME_BITS  = START_BITS + DATA_BITS + PARITY_BITS + STOP_BITS;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAITHI
  } rx_state_t;

  // Even parity over data plus the received parity bit; 1 means the frame is corrupt.
  function automatic logic even_par_err(input logic [DATA_BITS-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction

endpackage

// File: rtl/com_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle (1).
`timescale 1ns/1ps
module com_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/com_to_in.sv
// UART receiver: oversampled start/data/parity/stop framing with break handling.
// Macro COM_RX_PARITY_EN enables the even parity bit; otherwise frames are 10 bits and parErr stays 0.
`timescale 1ns/1ps
module com_to_in
  import com_pkg::*;
#(
  parameter int OVS = OVS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx,
  output logic [7:0] data,
  output logic       isFinish,
  output logic       parErr,
  output logic       frameErr,
  output logic       busy
);

  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVS / 2 - 1);

  logic            rxs;
  rx_state_t       state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      shreg, shreg_n;
  logic [7:0]      data_n;
  logic            frame_err_n;
  logic            finish_n;

  com_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rxs)
  );

`ifdef COM_RX_PARITY_EN
  logic par_bad, par_bad_n;
  logic par_err_n;
`endif

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    shreg_n     = shreg;
    data_n      = data;
    frame_err_n = frameErr;
    finish_n    = 1'b0;
`ifdef COM_RX_PARITY_EN
    par_bad_n   = par_bad;
    par_err_n   = parErr;
`endif
    if (enable) begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state_n = START;
            cnt_n   = '0;
          end
        end
        START: begin
          // Mid-start-bit check rejects short glitches without reporting a frame.
          if (cnt == CNT_MID) begin
            cnt_n   = '0;
            idx_n   = '0;
            state_n = rxs ? IDLE : DATA;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt_n          = '0;
            shreg_n[idx]   = rxs;
            if (idx == 3'd7) begin
              idx_n = '0;
`ifdef COM_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              idx_n = idx + 3'd1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        PARITY: begin
`ifdef COM_RX_PARITY_EN
          if (cnt == CNT_LAST) begin
            cnt_n     = '0;
            par_bad_n = even_par_err(shreg, rxs);
            state_n   = STOP;
          end else begin
            cnt_n = cnt + 1'b1;
          end
`else
          state_n = IDLE;
`endif
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt_n       = '0;
            data_n      = shreg;
            frame_err_n = ~rxs;
            finish_n    = 1'b1;
`ifdef COM_RX_PARITY_EN
            par_err_n   = par_bad;
`endif
            // A low stop bit may be a break; wait for the line to recover before hunting.
            state_n     = rxs ? IDLE : WAITHI;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        WAITHI: begin
          if (rxs) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      data     <= 8'h00;
      frameErr <= 1'b0;
      isFinish <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shreg    <= shreg_n;
      data     <= data_n;
      frameErr <= frame_err_n;
      isFinish <= finish_n;
    end
  end

`ifdef COM_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bad <= 1'b0;
      parErr  <= 1'b0;
    end else begin
      par_bad <= par_bad_n;
      parErr  <= par_err_n;
    end
  end
`else
  assign parErr = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_com_to_in.sv
// Directed bench for com_to_in: good, bad-parity, glitch, break, mid-frame reset and back-to-back frames.
`timescale 1ns/1ps
module tb_com_to_in;

  localparam int OVS      = 16;
  localparam int TICK_DIV = 4;
  localparam int CLK_HALF = 5;
`ifdef COM_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
  localparam int NBITS  = 11;
`else
  localparam bit PAR_ON = 1'b0;
  localparam int NBITS  = 10;
`endif
  localparam int FRAME_NS = NBITS * OVS * TICK_DIV * 2 * CLK_HALF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       isFinish;
  logic       parErr;
  logic       frameErr;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int fin_cnt = 0;
  int wide_pulse = 0;
  time        fin_time[$];
  logic [7:0] fin_data[$];

  com_to_in #(.OVS(OVS)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .rx       (rx),
    .data     (data),
    .isFinish (isFinish),
    .parErr   (parErr),
    .frameErr (frameErr),
    .busy     (busy)
  );

  always #CLK_HALF clk = ~clk;

  initial begin : tick_gen
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      enable = (div == TICK_DIV - 1);
      div = (div + 1) % TICK_DIV;
    end
  end

  initial begin : finish_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (isFinish) begin
        fin_cnt++;
        fin_time.push_back($time);
        fin_data.push_back(data);
      end
      if (isFinish && prev) wide_pulse++;
      prev = isFinish;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!enable);
    end
  endtask

  task automatic drive(input logic b, input int n);
    rx = b;
    ticks(n);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
    drive(1'b0, OVS);
    for (int i = 0; i < 8; i++) drive(b[i], OVS);
    if (PAR_ON) drive(par, OVS);
    drive(stp, OVS);
  endtask

  initial begin : stim
    int f0;
    int k;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_data", {24'd0, data}, 32'h00);
    chk("rst_finish", {31'd0, isFinish}, 32'd0);
    chk("rst_parerr", {31'd0, parErr}, 32'd0);
    chk("rst_frameerr", {31'd0, frameErr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    ticks(5);
    #1;

    f0 = fin_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    chk("a5_count", fin_cnt, f0 + 1);
    chk("a5_data", {24'd0, data}, 32'hA5);
    chk("a5_parerr", {31'd0, parErr}, 32'd0);
    chk("a5_frameerr", {31'd0, frameErr}, 32'd0);

    f0 = fin_cnt;
    send_frame(8'h07, 1'b0, 1'b1);
    chk("p07_count", fin_cnt, f0 + 1);
    chk("p07_data", {24'd0, data}, 32'h07);
    chk("p07_parerr", {31'd0, parErr}, PAR_ON ? 32'd1 : 32'd0);
    chk("p07_frameerr", {31'd0, frameErr}, 32'd0);

    f0 = fin_cnt;
    drive(1'b0, 4);
    drive(1'b1, 30);
    chk("glitch_busy", {31'd0, busy}, 32'd0);
    chk("glitch_count", fin_cnt, f0);
    chk("glitch_data", {24'd0, data}, 32'h07);

    f0 = fin_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    drive(1'b0, 40);
    chk("brk_count", fin_cnt, f0 + 1);
    chk("brk_data", {24'd0, data}, 32'h3C);
    chk("brk_frameerr", {31'd0, frameErr}, 32'd1);
    chk("brk_waithi_busy", {31'd0, busy}, 32'd1);
    drive(1'b1, 20);
    chk("brk_idle_busy", {31'd0, busy}, 32'd0);

    f0 = fin_cnt;
    send_frame(8'h55, 1'b0, 1'b1);
    chk("p55_count", fin_cnt, f0 + 1);
    chk("p55_data", {24'd0, data}, 32'h55);
    chk("p55_frameerr", {31'd0, frameErr}, 32'd0);
    chk("p55_parerr", {31'd0, parErr}, 32'd0);

    // Abandon a frame partway through data bit 4.
    f0 = fin_cnt;
    drive(1'b0, OVS);
    drive(1'b1, OVS);
    drive(1'b0, OVS);
    drive(1'b1, OVS);
    drive(1'b0, OVS);
    drive(1'b1, 8);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_count", fin_cnt, f0);
    chk("mid_rst_data", {24'd0, data}, 32'h00);
    chk("mid_rst_parerr", {31'd0, parErr}, 32'd0);
    chk("mid_rst_frameerr", {31'd0, frameErr}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    ticks(20);
    #1;

    f0 = fin_cnt;
    send_frame(8'h81, 1'b0, 1'b1);
    chk("p81_count", fin_cnt, f0 + 1);
    chk("p81_data", {24'd0, data}, 32'h81);
    chk("p81_parerr", {31'd0, parErr}, 32'd0);
    chk("p81_frameerr", {31'd0, frameErr}, 32'd0);

    k = fin_cnt;
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'hEE, 1'b0, 1'b1);
    drive(1'b1, 4);
    chk("b2b_count", fin_cnt, k + 2);
    if (fin_data.size() >= k + 2) begin
      chk("b2b_data0", {24'd0, fin_data[k]}, 32'h11);
      chk("b2b_data1", {24'd0, fin_data[k+1]}, 32'hEE);
      chk("b2b_period", 32'(fin_time[k+1] - fin_time[k]), FRAME_NS);
    end else begin
      chk("b2b_pulses_seen", fin_data.size(), k + 2);
    end
    chk("pulse_width", wide_pulse, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
